// File: rtl/dma_io_device.sv
// Device end of a DMAC DREQ/DACK cycle-steal handshake: byte FIFO, RDY wait states, EOP termination.
// Build option DMA_IO_DEV_XFER_CNT_EN implements the XFER_CNT counter; otherwise XFER_CNT reads 0.
module dma_io_device #(
    parameter int DEPTH       = 4,
    parameter int WAIT_STATES = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic        MODE,
    input  logic        DACK,
    input  logic        IOW,
    input  logic        IOR,
    input  logic        EOP,
    input  logic [7:0]  Data_in,
    output logic        DREQ,
    output logic        RDY,
    output logic [7:0]  Data_out,
    input  logic        L_POP,
    input  logic        L_PUSH,
    input  logic [7:0]  L_DIN,
    output logic [7:0]  L_DATA,
    output logic        L_VALID,
    output logic        L_FULL,
    output logic        DONE,
    output logic        ERR,
    output logic [15:0] XFER_CNT
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RELEASE, S_TERM} state_t;

    state_t        state_q, state_d;
    logic          mode_q, mode_d;
    logic [3:0]    wcnt_q, wcnt_d;
    logic          eop_pend_q, eop_pend_d;
    logic          dreq_q, dreq_d;
    logic          rdy_q, rdy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          l_valid_q, l_valid_d, l_full_q, l_full_d;
    logic [7:0]    mem_q [DEPTH];

    logic          eff_mode, strobe, empty, full, reqok;
    logic          bus_xfer, push, pop;
    logic [7:0]    push_data;

    // In IDLE the MODE pin is live (it is being latched), elsewhere the latched copy rules.
    always_comb begin
        eff_mode = (state_q == S_IDLE) ? MODE : mode_q;
        strobe   = DACK && (eff_mode ? IOR : IOW);
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        reqok    = eff_mode ? !empty : !full;
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        wcnt_d     = wcnt_q;
        eop_pend_d = eop_pend_q;
        err_d      = err_q;
        bus_xfer   = 1'b0;
        case (state_q)
            S_IDLE: begin
                mode_d = MODE;
                if (EOP)        state_d = S_TERM;
                else if (reqok) state_d = S_REQ;
            end
            S_REQ: begin
                if (EOP) begin
                    state_d = S_TERM;
                end else if (strobe) begin
                    if (WAIT_STATES == 0) begin
                        bus_xfer = 1'b1;
                        state_d  = S_RELEASE;
                    end else begin
                        wcnt_d  = 4'(WAIT_STATES);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (EOP) eop_pend_d = 1'b1;
                if (!DACK) begin
                    state_d = (EOP || eop_pend_q) ? S_TERM : S_REQ;
                end else begin
                    if (wcnt_q != 4'd0) wcnt_d = wcnt_q - 4'd1;
                    // The strobe that lands as the counter reaches zero completes the transfer.
                    if ((wcnt_q <= 4'd1) && strobe) begin
                        bus_xfer = 1'b1;
                        state_d  = (EOP || eop_pend_q) ? S_TERM : S_RELEASE;
                    end
                end
            end
            S_RELEASE: begin
                if (EOP)        state_d = S_TERM;
                else if (reqok) state_d = S_REQ;
                else            state_d = S_IDLE;
            end
            S_TERM:  state_d = S_TERM;
            default: state_d = S_IDLE;
        endcase
        if (strobe && ((state_q == S_IDLE) || (state_q == S_RELEASE) || (state_q == S_TERM)))
            err_d = 1'b1;
        if (!EN) begin
            state_d  = S_IDLE;
            bus_xfer = 1'b0;
        end
        if (state_d != S_WAIT) eop_pend_d = 1'b0;
        dreq_d = (state_d == S_REQ) || (state_d == S_WAIT);
        rdy_d  = !((state_d == S_WAIT) && (wcnt_d != 4'd0));
        done_d = (state_d == S_TERM);
    end

    // Bus side and local side act on opposite FIFO ends, so both may fire in one cycle.
    always_comb begin
        push      = 1'b0;
        pop       = 1'b0;
        push_data = Data_in;
        if (bus_xfer) begin
            if (mode_q) pop = 1'b1;
            else        push = 1'b1;
        end
        if (eff_mode) begin
            if (L_PUSH && !full) begin
                push      = 1'b1;
                push_data = L_DIN;
            end
        end else if (L_POP && !empty) begin
            pop = 1'b1;
        end
        wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q + CW'(push) - CW'(pop);
        l_valid_d = (count_d != '0);
        l_full_d  = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            wcnt_q     <= 4'd0;
            eop_pend_q <= 1'b0;
            dreq_q     <= 1'b0;
            rdy_q      <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            l_valid_q  <= 1'b0;
            l_full_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            wcnt_q     <= wcnt_d;
            eop_pend_q <= eop_pend_d;
            dreq_q     <= dreq_d;
            rdy_q      <= rdy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            l_valid_q  <= l_valid_d;
            l_full_q   <= l_full_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

`ifdef DMA_IO_DEV_XFER_CNT_EN
    logic [15:0] xfer_cnt_q, xfer_cnt_d;

    always_comb xfer_cnt_d = bus_xfer ? xfer_cnt_q + 16'd1 : xfer_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) xfer_cnt_q <= 16'h0000;
        else     xfer_cnt_q <= xfer_cnt_d;
    end

    assign XFER_CNT = xfer_cnt_q;
`else
    assign XFER_CNT = 16'h0000;
`endif

    assign DREQ     = dreq_q;
    assign RDY      = rdy_q;
    assign DONE     = done_q;
    assign ERR      = err_q;
    assign L_VALID  = l_valid_q;
    assign L_FULL   = l_full_q;
    assign L_DATA   = mem_q[rd_ptr_q];
    assign Data_out = (DACK && IOR && eff_mode) ? mem_q[rd_ptr_q] : 8'h00;

endmodule

// File: doc/dma_io_device.md
# dma_io_device

DMA-capable I/O peripheral that sits on the device end of the DMAC request/acknowledge handshake. It raises DREQ, answers DACK qualified by IOW or IOR, and inserts wait states through RDY. It buffers bytes in a small FIFO and stops requesting on EOP. It is the counterpart the DMAC exercises in memory-to-I/O and I/O-to-memory cycle-steal flyby transfers.

## Interface
- DEPTH, 4: FIFO depth in bytes; power of two, at least 2.
- WAIT_STATES, 0: RDY-low cycles inserted per bus transfer, 0–15.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- EN  in  1  device enable; 0 forces IDLE and clears DONE.
- MODE  in  1  0 = sink (memory-to-I/O, IOW writes FIFO); 1 = source (I/O-to-memory, IOR reads FIFO); sampled only in IDLE.
- DACK  in  1  DMA acknowledge from DMAC.
- IOW  in  1  I/O write strobe, active-high.
- IOR  in  1  I/O read strobe, active-high.
- EOP  in  1  end of process from DMAC.
- Data_in  in  8  bus data into device (sink mode).
- DREQ  out  1  DMA request.
- RDY  out  1  ready; 0 extends current transfer.
- Data_out  out  8  bus data from device (source mode).
- L_POP, L_PUSH  in  1  local-side FIFO pop (sink) / push (source).
- L_DIN  in  8  local push data.
- L_DATA  out  8  FIFO head (combinational from storage).
- L_VALID, L_FULL  out  1  FIFO non-empty / full.
- DONE  out  1  sticky, EOP received.
- ERR  out  1  sticky, spurious strobe.
- XFER_CNT  out  16  completed bus transfers.

## Operation
- Reset values: DREQ=0, RDY=1, Data_out=0, L_VALID=0, L_FULL=0, DONE=0, ERR=0, XFER_CNT=0. The FIFO is emptied and the FSM is in IDLE.
- Request condition REQOK: sink mode requires FIFO not full; source mode requires FIFO not empty.
- FSM states: IDLE, REQ, WAIT, RELEASE, TERM.
  - IDLE: latches MODE. Moves to REQ when EN && REQOK && !DONE.
  - REQ: DREQ=1. A bus strobe is DACK && (MODE ? IOR : IOW).
    - On a strobe with WAIT_STATES=0, complete the transfer at this edge and go to RELEASE.
    - On a strobe with WAIT_STATES>0, load the wait counter and go to WAIT.
  - WAIT: RDY=0 and DREQ=1. The counter decrements each cycle. When the counter reaches 0, RDY returns to 1; the transfer completes on the next strobe-qualified edge, then go to RELEASE. If DACK drops while in WAIT, abort with no FIFO change and return to REQ.
  - RELEASE: DREQ=0 for exactly one cycle, which provides the cycle-steal hand-back. Then go to REQ if REQOK, else IDLE.
  - TERM: DREQ=0 and DONE=1. Stays in TERM until EN=0, then IDLE with DONE cleared.
- Transfer completion:
  - Sink: push Data_in.
  - Source: pop the head.
  - Both: XFER_CNT increments and wraps 0xFFFF→0.
- Data_out equals the FIFO head while DACK && IOR && MODE=1; otherwise 8'h00.
- EOP handling:
  - Sampled high in REQ or RELEASE: go to TERM.
  - Sampled high in WAIT: finish the current transfer first, then TERM.
  - Sampled high in IDLE: TERM.
- Strobes without DACK are ignored.
- DACK plus a mode strobe outside REQ/WAIT sets ERR, with no FIFO change. ERR clears only on RST.
- Local side: L_PUSH is ignored in sink mode or when full. L_POP is ignored in source mode or when empty.
- Simultaneous local and bus operations on the same cycle (a bus push with an L_POP, or a bus pop with an L_PUSH) are both performed; the count is unchanged. Pointers wrap modulo DEPTH.
- EN=0 in any state: next state is IDLE, DREQ=0, RDY=1. The FIFO contents are kept.
- RST mid-transfer: all outputs return to reset values on the next edge and the FIFO is flushed.

## Timing
- All outputs are registered except L_DATA and Data_out.
- Latency, IDLE to DREQ high: 1 cycle after EN && REQOK is sampled.
- Transfer duration with WAIT_STATES=N: N+1 strobe-qualified cycles from the first DACK-and-strobe edge to completion. RDY is low for exactly N cycles.
- Minimum DREQ period between back-to-back transfers: 1 RELEASE cycle.
- FIFO flags update on the edge after a push or pop.

## Configuration
- DMA_IO_DEV_XFER_CNT_EN defined: the 16-bit XFER_CNT counter is implemented as described.
- Not defined: XFER_CNT is tied to 16'h0000 and no counter flops exist. All other behaviour is identical.

## Test plan
- Sink, WAIT_STATES=0, DEPTH=4: EN=1 with DREQ pulsed three times by DACK+IOW carrying 0x05, 0x0A, 0x0F → L_DATA pops 0x05, 0x0A, 0x0F; XFER_CNT=3; DREQ low one cycle after each transfer.
- Sink, fill to full: four IOW transfers with no L_POP → L_FULL=1 and DREQ stays 0. One L_POP → DREQ=1 within 2 cycles.
- Source, WAIT_STATES=2: L_PUSH 0xA5 then DACK+IOR held → RDY low for exactly 2 cycles, Data_out=0xA5 during the strobe, FIFO empty after completion, DREQ=0.
- EOP during WAIT (WAIT_STATES=3): the transfer still completes (XFER_CNT+1), the state becomes TERM, DONE=1, and DREQ stays 0. EN=0 then EN=1 → DONE clears and DREQ resumes.
- Spurious strobe: DACK+IOW while in IDLE → ERR=1, FIFO count unchanged. RST → ERR=0.
- Reset mid-WAIT: RST asserted with RDY=0 → next edge RDY=1, DREQ=0, L_VALID=0, XFER_CNT=0.
